// File: rtl/orb_m16.sv
// RS-485 polling master: periodic one-byte request, fixed-length reply capture,
// and a continuous MSB-first serial stream of the last accepted packet.
module orb_m16 #(
    parameter int         CLK_PER_BIT = 42,
    parameter int         NUM_BYTES   = 20,
    parameter logic [7:0] REQ_BYTE    = 8'hA5,
    parameter int         REQ_PERIOD  = 40000,
    parameter int         RX_TIMEOUT  = 4200,
    parameter int         ORB_DIV     = 100
) (
    input  logic clk100MHz,
    input  logic rst,
    input  logic UART_RX,
    output logic UART_TX,
    output logic UART_dTX,
    output logic UART_dRX,
    output logic ValRX,
    output logic doubleOrbData,
    output logic test1,
    output logic test2,
    output logic test3,
    output logic test4
);

    localparam int CW   = $clog2(CLK_PER_BIT);
    localparam int RW   = $clog2(REQ_PERIOD);
    localparam int TW   = $clog2(RX_TIMEOUT);
    localparam int DW   = $clog2(ORB_DIV);
    localparam int NW   = $clog2(NUM_BYTES + 1);
    localparam int HALF = CLK_PER_BIT / 2;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // ---------------- request timer ----------------
    logic [RW-1:0] req_cnt;
    logic          req_start;

    assign req_start = (req_cnt == RW'(REQ_PERIOD - 1));

    always_ff @(posedge clk100MHz) begin
        if (rst)            req_cnt <= '0;
        else if (req_start) req_cnt <= '0;
        else                req_cnt <= req_cnt + 1'b1;
    end

    // ---------------- transmitter ----------------
    tx_state_t     tx_state, tx_next;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_idx;
    logic          tx_bit_end;

    assign tx_bit_end = (tx_cnt == CW'(CLK_PER_BIT - 1));

    always_comb begin
        tx_next  = tx_state;
        UART_TX  = 1'b1;
        UART_dTX = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (req_start) tx_next = TX_START;
            end
            TX_START: begin
                UART_TX  = 1'b0;
                UART_dTX = 1'b1;
                if (tx_bit_end) tx_next = TX_DATA;
            end
            TX_DATA: begin
                UART_TX  = REQ_BYTE[tx_idx];
                UART_dTX = 1'b1;
                if (tx_bit_end && tx_idx == 3'd7) tx_next = TX_STOP;
            end
            TX_STOP: begin
                UART_dTX = 1'b1;
                if (tx_bit_end) tx_next = TX_IDLE;
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    assign UART_dRX = UART_dTX;
    assign test2    = UART_dTX;

    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
        end else begin
            tx_state <= tx_next;
            if (tx_state == TX_IDLE || tx_bit_end) tx_cnt <= '0;
            else                                   tx_cnt <= tx_cnt + 1'b1;
            if (tx_state != TX_DATA) tx_idx <= '0;
            else if (tx_bit_end)     tx_idx <= tx_idx + 1'b1;
        end
    end

    // ---------------- receiver ----------------
    rx_state_t                    rx_state, rx_next;
    logic                         rx_s1, rx_s2, rx_prev;
    logic [CW-1:0]                rx_cnt;
    logic [2:0]                   rx_idx;
    logic [7:0]                   rx_sh;
    logic [NW-1:0]                byte_cnt;
    logic                         rx_lock;
    logic [TW-1:0]                idle_cnt;
    logic [NUM_BYTES-1:0][7:0]    rx_buf;
    logic                         rx_sample, rx_fall, rx_ena;
    logic                         stop_ok, stop_bad, store, rx_waiting, rx_tmo;

    assign rx_fall    = rx_prev & ~rx_s2;
    assign rx_ena     = ~UART_dRX & ~rx_lock;
    assign rx_sample  = (rx_state == RX_START) ? (rx_cnt == CW'(HALF - 1))
                                               : (rx_cnt == CW'(CLK_PER_BIT - 1));
    // A request wins over a stop bit landing on the same clock.
    assign stop_ok    = (rx_state == RX_STOP) && rx_sample &&  rx_s2 && !req_start;
    assign stop_bad   = (rx_state == RX_STOP) && rx_sample && !rx_s2 && !req_start;
    assign store      = stop_ok && (byte_cnt < NW'(NUM_BYTES));
    assign rx_waiting = (rx_state == RX_IDLE) && (byte_cnt != '0)
                        && (byte_cnt < NW'(NUM_BYTES));
    assign rx_tmo     = rx_waiting && (idle_cnt == TW'(RX_TIMEOUT - 1));

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_ena && rx_fall) rx_next = RX_START;
            RX_START: if (rx_sample) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_sample && rx_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_sample) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
        if (req_start || UART_dRX) rx_next = RX_IDLE;
    end

    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_sh    <= '0;
            byte_cnt <= '0;
            rx_lock  <= 1'b0;
            idle_cnt <= '0;
            rx_buf   <= '0;
            ValRX    <= 1'b0;
            test1    <= 1'b0;
        end else begin
            rx_s1    <= UART_RX;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_next;

            if (rx_state == RX_IDLE || rx_sample) rx_cnt <= '0;
            else                                  rx_cnt <= rx_cnt + 1'b1;

            if (rx_state != RX_DATA) rx_idx <= '0;
            else if (rx_sample)      rx_idx <= rx_idx + 1'b1;

            if (rx_state == RX_DATA && rx_sample) rx_sh <= {rx_s2, rx_sh[7:1]};

            if (req_start || stop_bad || rx_tmo) byte_cnt <= '0;
            else if (store)                      byte_cnt <= byte_cnt + 1'b1;

            // After a framing error the rest of the reply is noise; wait for a fresh poll.
            if (req_start)     rx_lock <= 1'b0;
            else if (stop_bad) rx_lock <= 1'b1;

            if (!rx_waiting || rx_tmo) idle_cnt <= '0;
            else                       idle_cnt <= idle_cnt + 1'b1;

            if (store) rx_buf[byte_cnt] <= rx_sh;

            ValRX <= store && (byte_cnt == NW'(NUM_BYTES - 1));
            test1 <= store;
        end
    end

    assign test3 = ValRX;

    // ---------------- output bank and serializer ----------------
    logic [NUM_BYTES-1:0][7:0] bank, shadow;
    logic [DW-1:0]             orb_div;
    logic [2:0]                orb_bit;
    logic [NW-1:0]             orb_byte;
    logic                      div_end, frame_wrap;

    assign div_end    = (orb_div == DW'(ORB_DIV - 1));
    assign frame_wrap = div_end && (orb_bit == 3'd7) && (orb_byte == NW'(NUM_BYTES - 1));

    always_ff @(posedge clk100MHz) begin
        if (rst)        bank <= '0;
        else if (ValRX) bank <= rx_buf;
    end

    // The shadow only changes at a frame boundary so a frame is never torn.
    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            orb_div  <= '0;
            orb_bit  <= '0;
            orb_byte <= '0;
            shadow   <= '0;
            test4    <= 1'b0;
        end else begin
            test4 <= frame_wrap;
            if (frame_wrap) shadow <= bank;
            if (div_end) orb_div <= '0;
            else         orb_div <= orb_div + 1'b1;
            if (div_end) begin
                orb_bit <= orb_bit + 1'b1;
                if (orb_bit == 3'd7) begin
                    if (orb_byte == NW'(NUM_BYTES - 1)) orb_byte <= '0;
                    else                                 orb_byte <= orb_byte + 1'b1;
                end
            end
        end
    end

    assign doubleOrbData = shadow[orb_byte][3'd7 - orb_bit];

endmodule

// File: tb/tb_orb_m16.sv
// Directed bench for orb_m16: reset state, request framing, reply capture,
// error/timeout rejection and the serial output bank.
module tb_orb_m16;

    localparam int CPB = 8;
    localparam int NB  = 20;
    localparam int REQ = 6000;
    localparam int TO  = 800;
    localparam int OD  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic UART_TX, UART_dTX, UART_dRX, ValRX, doubleOrbData;
    logic test1, test2, test3, test4;

    always #5 clk = ~clk;

    orb_m16 #(
        .CLK_PER_BIT(CPB), .NUM_BYTES(NB), .REQ_BYTE(8'hA5),
        .REQ_PERIOD(REQ), .RX_TIMEOUT(TO), .ORB_DIV(OD)
    ) dut (
        .clk100MHz(clk), .rst(rst), .UART_RX(rx),
        .UART_TX(UART_TX), .UART_dTX(UART_dTX), .UART_dRX(UART_dRX),
        .ValRX(ValRX), .doubleOrbData(doubleOrbData),
        .test1(test1), .test2(test2), .test3(test3), .test4(test4)
    );

    int n_chk = 0;
    int n_fail = 0;
    int t1_cnt = 0;
    int val_cnt = 0;
    int val_hi = 0;
    logic val_d = 1'b0;

    logic [7:0] base [NB] = '{8'd0, 8'd100, 8'd150, 8'd200, 8'd250, 8'd44, 8'd94,
                              8'd144, 8'd194, 8'd244, 8'd38, 8'd88, 8'd138, 8'd188,
                              8'd238, 8'd32, 8'd82, 8'd132, 8'd182, 8'd232};
    logic [7:0] exp_bank [NB];

    always @(negedge clk) begin
        if (rst) begin
            val_d = 1'b0;
        end else begin
            if (test1) t1_cnt++;
            if (ValRX) val_hi++;
            if (ValRX && !val_d) val_cnt++;
            val_d = ValRX;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (10 * CPB) @(negedge clk);
    endtask

    task automatic wait_req(input string tag);
        bit seen = 0;
        for (int n = 0; n < REQ + 100; n++) begin
            @(negedge clk);
            if (UART_dRX) begin seen = 1; break; end
        end
        chk({tag, "_req"}, {31'd0, seen}, 32'd1);
        seen = 0;
        for (int n = 0; n < 20 * CPB; n++) begin
            @(negedge clk);
            if (!UART_dRX) begin seen = 1; break; end
        end
        chk({tag, "_drx_fall"}, {31'd0, seen}, 32'd1);
    endtask

    // mode 0: clean reply, 1: bad stop bit on byte 7, 2: timeout after byte 10
    task automatic do_poll(input bit wait_tx, input logic [7:0] b0, input int mode,
                           input string tag);
        int t1_0, v0, vh0;
        logic [7:0] pkt [NB];
        if (wait_tx) wait_req(tag);
        repeat (30 * CPB) @(negedge clk);
        t1_0 = t1_cnt; v0 = val_cnt; vh0 = val_hi;
        for (int i = 0; i < NB; i++) begin
            pkt[i] = (i == 0) ? b0 : base[i];
            if (mode == 2 && i == 10) repeat (120 * CPB) @(negedge clk);
            send_byte(pkt[i], !(mode == 1 && i == 7));
        end
        repeat (4) @(negedge clk);
        chk({tag, "_test1"}, t1_cnt - t1_0, (mode == 1) ? 7 : NB);
        chk({tag, "_valrx"}, val_cnt - v0, (mode == 0) ? 1 : 0);
        chk({tag, "_valrx_width"}, val_hi - vh0, (mode == 0) ? 1 : 0);
        if (mode == 0) for (int i = 0; i < NB; i++) exp_bank[i] = pkt[i];
    endtask

    task automatic check_frame(input string tag);
        bit seen = 0;
        logic [7:0] cur = 8'd0;
        @(negedge clk);
        for (int n = 0; n < 2 * NB * 8 * OD + 10; n++) begin
            @(negedge clk);
            if (test4) begin seen = 1; break; end
        end
        chk({tag, "_test4"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            for (int i = 0; i < NB * 8 * OD; i++) begin
                if (i == 1) chk({tag, "_test4_pulse"}, {31'd0, test4}, 32'd0);
                if (i % OD == OD / 2) begin
                    cur = {cur[6:0], doubleOrbData};
                    if ((i / OD) % 8 == 7)
                        chk($sformatf("%s_byte%0d", tag, i / (8 * OD)), cur,
                            exp_bank[i / (8 * OD)]);
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen;
        int hi_t, hi_r;
        logic [9:0] fr;
        for (int i = 0; i < NB; i++) exp_bank[i] = 8'd0;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", {31'd0, UART_TX}, 32'd1);
        chk("rst_dtx", {31'd0, UART_dTX}, 32'd0);
        chk("rst_drx", {31'd0, UART_dRX}, 32'd0);
        chk("rst_valrx", {31'd0, ValRX}, 32'd0);
        chk("rst_orb", {31'd0, doubleOrbData}, 32'd0);
        chk("rst_test4", {31'd0, test4}, 32'd0);
        rst = 1'b0;

        seen = 0;
        for (int n = 0; n < REQ + 20; n++) begin
            @(negedge clk);
            if (UART_dTX) begin seen = 1; break; end
        end
        chk("first_req", {31'd0, seen}, 32'd1);
        fr = {1'b1, 8'hA5, 1'b0};
        hi_t = 0; hi_r = 0;
        for (int i = 0; i < 10 * CPB + 4; i++) begin
            hi_t += int'(UART_dTX);
            hi_r += int'(UART_dRX);
            if (i < 10 * CPB && i % CPB == CPB / 2)
                chk($sformatf("tx_bit%0d", i / CPB), {31'd0, UART_TX}, {31'd0, fr[i / CPB]});
            @(negedge clk);
        end
        chk("dtx_width", hi_t, 10 * CPB);
        chk("drx_width", hi_r, 10 * CPB);
        chk("tx_idle", {31'd0, UART_TX}, 32'd1);

        do_poll(1'b0, 8'd0, 0, "p0");
        check_frame("f0");
        for (int k = 1; k <= 4; k++) begin
            do_poll(1'b1, 8'(k * 8), 0, $sformatf("p%0d", k));
            check_frame($sformatf("f%0d", k));
        end
        do_poll(1'b1, 8'd40, 1, "ferr");
        check_frame("f_ferr");
        do_poll(1'b1, 8'd48, 2, "tmo");
        check_frame("f_tmo");
        do_poll(1'b1, 8'd56, 0, "rec");
        check_frame("f_rec");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/orb_m16.md
Name: orb_m16

Overview:
- RS-485 UART polling master plus Orbita-style serial telemetry output.
- Periodically transmits a one-byte request to a remote unit, then receives a fixed 20-byte reply.
- Flags each complete, error-free packet on ValRX and latches it into an output bank.
- The output bank is streamed continuously on doubleOrbData for the telemetry frame mux.

Parameters:
- CLK_PER_BIT, 42, clocks per UART bit (2.38 Mbaud at 100 MHz).
- NUM_BYTES, 20, bytes per reply packet.
- REQ_BYTE, 8'hA5, request byte value.
- REQ_PERIOD, 40000, clocks between successive request starts (400 us).
- RX_TIMEOUT, 4200, idle clocks (100 bit times) after which a partial packet is discarded.
- ORB_DIV, 100, clocks per output bit on doubleOrbData.

Ports:
- clk100MHz  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- UART_RX  in  1  serial receive line, idle high.
- UART_TX  out  1  serial transmit line, idle high.
- UART_dTX  out  1  RS-485 driver enable, high while transmitting.
- UART_dRX  out  1  RS-485 receiver disable, high while transmitting.
- ValRX  out  1  one-clock pulse: complete packet accepted.
- doubleOrbData  out  1  serial output of the latched packet.
- test1  out  1  one-clock pulse per received byte.
- test2  out  1  copy of UART_dTX.
- test3  out  1  copy of ValRX.
- test4  out  1  one-clock pulse at the start of each output frame (bit 7 of byte 0).

Behaviour:
- Reset values:
  - UART_TX=1; UART_dTX=0; UART_dRX=0; ValRX=0; doubleOrbData=0; test1..test4=0.
  - All counters 0; output bank all zeros.
  - Reset mid-operation aborts any TX/RX immediately.
- Request timer:
  - Free-running counter 0..REQ_PERIOD-1.
  - When it wraps to 0, the TX state machine starts a request (first request at the first wrap after reset).
- TX state machine: IDLE -> START -> DATA -> STOP -> IDLE, each bit CLK_PER_BIT clocks.
  - Frame is 8N1: start bit 0, then REQ_BYTE LSB first, then stop bit 1.
  - UART_dTX and UART_dRX are high from the first clock of START through the last clock of STOP, and drop to 0 together on return to IDLE.
  - The receive byte counter clears when the request starts.
- RX state machine: IDLE -> START -> DATA -> STOP.
  - Input is double-flop synchronised.
  - Falling edge in IDLE enters START; the line is sampled at CLK_PER_BIT/2. If high, the start is false and the machine returns to IDLE.
  - Data bits are sampled every CLK_PER_BIT at mid-bit, LSB first.
  - Stop bit sampled at mid-bit:
    - If 1: byte stored at buf[byte_cnt], byte_cnt++, test1 pulses.
    - If 0: framing error; the packet is discarded (byte_cnt=0) and the machine waits for the next request.
  - RX is ignored while UART_dRX=1.
  - Gap between bytes is arbitrary up to RX_TIMEOUT. Exceeding the timeout with 0 < byte_cnt < NUM_BYTES clears byte_cnt.
  - Bytes beyond NUM_BYTES before the next request are ignored.
- Packet complete (byte_cnt reaches NUM_BYTES):
  - ValRX pulses for exactly one clock, on the clock after the last stop-bit sample.
  - The output bank is loaded from buf on the same clock.
  - Byte 0 is the remote frame counter. It is passed through, not checked.
- Output serializer:
  - Loops continuously over bank bytes 0..NUM_BYTES-1, MSB first, each bit held ORB_DIV clocks.
  - test4 pulses on the first clock of byte 0 bit 7.
  - A bank load mid-frame takes effect only at the next frame start: a shadow copy is taken when test4 fires.
- Simultaneous request-timer wrap while RX is mid-byte: the request wins. RX aborts, byte_cnt clears, TX starts.

Test Plan:
- Reset held 5 clocks -> UART_TX=1, dTX=dRX=0, ValRX=0, doubleOrbData=0.
- After first timer wrap -> UART_TX shows 0,1,0,1,0,0,1,0,1,1 (A5 LSB first), each 42 clocks; dTX/dRX high for exactly 420 clocks, then 0.
- 30 bit times after dRX falls, send 20 bytes (10 idle bits between bytes): 0,100,150,200,250,44,94,144,194,244,38,88,138,188,238,32,82,132,182,232 -> test1 pulses 20 times, ValRX one pulse, bank matches.
- Next frame start after that load -> doubleOrbData reproduces the bank MSB first, 100 clocks per bit; test4 at frame start.
- Repeat 32 polls with byte 0 = 0,8,16,...,248 -> 32 ValRX pulses, bank byte 0 tracks the counter.
- Corrupt the stop bit of byte 7, or stop after 10 bytes and idle past RX_TIMEOUT -> no ValRX, bank unchanged; next good packet accepted.
